// File: rtl/itch_order_event_fifo_if.sv
// Order-event stream from the ITCH event FIFO to the order-book update logic.
// The master drives a show-ahead head entry; the slave accepts it with out_ready.
interface itch_order_event_fifo_if;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_type;
  logic [31:0] out_timeStamp;
  logic [63:0] out_orderID;
  logic [31:0] out_orderBookID;
  logic [7:0]  out_side;
  logic [63:0] out_quantity;
  logic [31:0] out_price;

  modport master (
    output out_valid, out_type, out_timeStamp, out_orderID, out_orderBookID,
           out_side, out_quantity, out_price,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_type, out_timeStamp, out_orderID, out_orderBookID,
           out_side, out_quantity, out_price,
    output out_ready
  );
endinterface

// File: rtl/itch_order_event_fifo.sv
// Normalises add/exec/delete parser strobes into order events and queues them
// in a show-ahead circular FIFO; lost events are tallied in a saturating counter.
module itch_order_event_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       add_valid,
  input  logic                       exec_valid,
  input  logic                       del_valid,
  input  logic [31:0]                add_timeStamp,
  input  logic [31:0]                exec_timeStamp,
  input  logic [31:0]                del_timeStamp,
  input  logic [63:0]                add_orderID,
  input  logic [63:0]                exec_orderID,
  input  logic [63:0]                del_orderID,
  input  logic [31:0]                add_orderBookID,
  input  logic [31:0]                exec_orderBookID,
  input  logic [31:0]                del_orderBookID,
  input  logic [7:0]                 add_side,
  input  logic [7:0]                 exec_side,
  input  logic [7:0]                 del_side,
  input  logic [63:0]                add_quantity,
  input  logic [63:0]                exec_executedQuantity,
  input  logic [31:0]                add_price,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           drop_cnt,
  itch_order_event_fifo_if.master    ev
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [1:0]  ev_type;
    logic [31:0] ts;
    logic [63:0] order_id;
    logic [31:0] book_id;
    logic [7:0]  side;
    logic [63:0] qty;
    logic [31:0] price;
  } entry_t;

  entry_t                 cand_entry;
  logic                   cand;
  logic [1:0]             n_strobe;
  logic [1:0]             n_loss;
  logic [1:0]             drop_inc;
  logic [CNT_W:0]         drop_sum;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]          level_w;
  logic [CNT_W-1:0]       drop_q, drop_d;
  logic                   empty, full, push, pop, overflow;
  entry_t [DEPTH-1:0]     slots;
  entry_t                 head;

  // Fixed priority ADD > EXEC > DELETE; missing fields of the winner are zero.
  always_comb begin
    cand_entry = '0;
    cand       = 1'b1;
    if (add_valid) begin
      cand_entry = '{2'd0, add_timeStamp, add_orderID, add_orderBookID,
                     add_side, add_quantity, add_price};
    end else if (exec_valid) begin
      cand_entry = '{2'd1, exec_timeStamp, exec_orderID, exec_orderBookID,
                     exec_side, exec_executedQuantity, 32'd0};
    end else if (del_valid) begin
      cand_entry = '{2'd2, del_timeStamp, del_orderID, del_orderBookID,
                     del_side, 64'd0, 32'd0};
    end else begin
      cand = 1'b0;
    end
  end

  assign level_w  = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (level_w == PW'(DEPTH));
  assign pop      = !empty && ev.out_ready;
  assign push     = cand && (!full || pop);
  assign overflow = cand && full && !pop;

  assign n_strobe = 2'(add_valid) + 2'(exec_valid) + 2'(del_valid);
  assign n_loss   = n_strobe - 2'(cand);
  assign drop_inc = n_loss + 2'(overflow);
  assign drop_sum = {1'b0, drop_q} + (CNT_W + 1)'(drop_inc);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    drop_d   = (drop_sum > {1'b0, CNT_MAX}) ? CNT_MAX : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      drop_q   <= drop_d;
    end
  end

  // One register slot per entry; cleared on reset so the idle head reads zero.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      entry_t slot_q;
      always_ff @(posedge clk) begin
        if (!rst) begin
          slot_q <= '0;
        end else if (push && (wr_ptr_q[AW-1:0] == AW'(gi))) begin
          slot_q <= cand_entry;
        end
      end
      assign slots[gi] = slot_q;
    end
  endgenerate

  assign head = slots[rd_ptr_q[AW-1:0]];

  assign ev.out_valid       = !empty;
  assign ev.out_type        = head.ev_type;
  assign ev.out_timeStamp   = head.ts;
  assign ev.out_orderID     = head.order_id;
  assign ev.out_orderBookID = head.book_id;
  assign ev.out_side        = head.side;
  assign ev.out_quantity    = head.qty;
  assign ev.out_price       = head.price;

  assign level    = level_w;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_itch_order_event_fifo.sv
// Directed bench for itch_order_event_fifo: normalisation, ordering, overflow,
// priority losses, counter saturation and mid-stream reset.
module tb_itch_order_event_fifo;
  localparam int DEPTH = 8;
  localparam int CNT_W = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        add_valid = 0, exec_valid = 0, del_valid = 0;
  logic [31:0] add_timeStamp = 0, exec_timeStamp = 0, del_timeStamp = 0;
  logic [63:0] add_orderID = 0, exec_orderID = 0, del_orderID = 0;
  logic [31:0] add_orderBookID = 0, exec_orderBookID = 0, del_orderBookID = 0;
  logic [7:0]  add_side = 0, exec_side = 0, del_side = 0;
  logic [63:0] add_quantity = 0, exec_executedQuantity = 0;
  logic [31:0] add_price = 0;
  logic [3:0]  level;
  logic [CNT_W-1:0] drop_cnt;

  int checks = 0;
  int failures = 0;

  itch_order_event_fifo_if ev_if ();

  itch_order_event_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .add_valid(add_valid), .exec_valid(exec_valid), .del_valid(del_valid),
    .add_timeStamp(add_timeStamp), .exec_timeStamp(exec_timeStamp),
    .del_timeStamp(del_timeStamp),
    .add_orderID(add_orderID), .exec_orderID(exec_orderID), .del_orderID(del_orderID),
    .add_orderBookID(add_orderBookID), .exec_orderBookID(exec_orderBookID),
    .del_orderBookID(del_orderBookID),
    .add_side(add_side), .exec_side(exec_side), .del_side(del_side),
    .add_quantity(add_quantity), .exec_executedQuantity(exec_executedQuantity),
    .add_price(add_price),
    .level(level), .drop_cnt(drop_cnt),
    .ev(ev_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_add(input logic [63:0] id, input logic [63:0] qty,
                           input logic [31:0] price, input logic [7:0] side);
    add_valid = 1; add_orderID = id; add_quantity = qty; add_price = price;
    add_side = side; add_timeStamp = 32'h1000; add_orderBookID = 32'd7;
  endtask

  task automatic check_head(input string tag, input logic [1:0] t, input logic [63:0] id,
                            input logic [63:0] qty, input logic [31:0] price);
    check_eq({tag, ".valid"}, 64'(ev_if.out_valid), 64'd1);
    check_eq({tag, ".type"},  64'(ev_if.out_type), 64'(t));
    check_eq({tag, ".id"},    ev_if.out_orderID, id);
    check_eq({tag, ".qty"},   ev_if.out_quantity, qty);
    check_eq({tag, ".price"}, 64'(ev_if.out_price), 64'(price));
  endtask

  initial begin
    ev_if.out_ready = 1'b0;
    tick(); tick();
    check_eq("rst.valid", 64'(ev_if.out_valid), 64'd0);
    check_eq("rst.level", 64'(level), 64'd0);
    check_eq("rst.drop",  64'(drop_cnt), 64'd0);
    check_eq("rst.id",    ev_if.out_orderID, 64'd0);
    check_eq("rst.price", 64'(ev_if.out_price), 64'd0);
    rst = 1'b1;
    tick();

    // Single add with consumer ready
    ev_if.out_ready = 1'b1;
    drive_add(64'h1122334455667788, 64'd100, 32'd2500, 8'h42);
    tick();
    add_valid = 0;
    check_head("single", 2'd0, 64'h1122334455667788, 64'd100, 32'd2500);
    check_eq("single.side",  64'(ev_if.out_side), 64'h42);
    check_eq("single.ts",    64'(ev_if.out_timeStamp), 64'h1000);
    check_eq("single.book",  64'(ev_if.out_orderBookID), 64'd7);
    check_eq("single.level", 64'(level), 64'd1);
    tick();
    check_eq("single.pop.valid", 64'(ev_if.out_valid), 64'd0);
    check_eq("single.pop.level", 64'(level), 64'd0);

    // Mixed stream held back, add fields left stale to expose bad muxing
    ev_if.out_ready = 1'b0;
    drive_add(64'hA1, 64'd500, 32'd2500, 8'h42);
    tick();
    add_valid = 0;
    exec_valid = 1; exec_orderID = 64'hE1; exec_executedQuantity = 64'd40;
    exec_side = 8'h53; exec_orderBookID = 32'd9; exec_timeStamp = 32'h2000;
    tick();
    exec_valid = 0;
    del_valid = 1; del_orderID = 64'hD1; del_side = 8'h42;
    del_orderBookID = 32'd11; del_timeStamp = 32'h3000;
    tick();
    del_valid = 0;
    check_eq("mixed.level", 64'(level), 64'd3);
    check_head("mixed.hold", 2'd0, 64'hA1, 64'd500, 32'd2500);
    tick();
    check_head("mixed.hold2", 2'd0, 64'hA1, 64'd500, 32'd2500);
    ev_if.out_ready = 1'b1;
    tick();
    check_head("mixed.exec", 2'd1, 64'hE1, 64'd40, 32'd0);
    check_eq("mixed.exec.side", 64'(ev_if.out_side), 64'h53);
    check_eq("mixed.exec.book", 64'(ev_if.out_orderBookID), 64'd9);
    tick();
    check_head("mixed.del", 2'd2, 64'hD1, 64'd0, 32'd0);
    check_eq("mixed.del.ts", 64'(ev_if.out_timeStamp), 64'h3000);
    tick();
    check_eq("mixed.empty", 64'(ev_if.out_valid), 64'd0);

    // Overflow: 10 adds into 8 slots
    ev_if.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_add(64'h100 + 64'(i), 64'd1, 32'd1, 8'h53);
      tick();
    end
    add_valid = 0;
    check_eq("ovf.level", 64'(level), 64'd8);
    check_eq("ovf.drop",  64'(drop_cnt), 64'd2);
    check_eq("ovf.head",  ev_if.out_orderID, 64'h100);

    // Full with simultaneous pop and push
    ev_if.out_ready = 1'b1;
    drive_add(64'h200, 64'd1, 32'd1, 8'h53);
    tick();
    add_valid = 0;
    ev_if.out_ready = 1'b0;
    check_eq("fullpp.level", 64'(level), 64'd8);
    check_eq("fullpp.drop",  64'(drop_cnt), 64'd2);
    ev_if.out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      check_eq($sformatf("drain.%0d", i), ev_if.out_orderID, 64'h100 + 64'(i));
      tick();
    end
    check_eq("drain.last", ev_if.out_orderID, 64'h200);
    tick();
    check_eq("drain.empty", 64'(ev_if.out_valid), 64'd0);

    // All three strobes into an empty FIFO
    ev_if.out_ready = 1'b0;
    drive_add(64'h300, 64'd7, 32'd8, 8'h42);
    exec_valid = 1; del_valid = 1;
    tick();
    add_valid = 0; exec_valid = 0; del_valid = 0;
    check_eq("tri.level", 64'(level), 64'd1);
    check_eq("tri.drop",  64'(drop_cnt), 64'd4);
    check_eq("tri.type",  64'(ev_if.out_type), 64'd0);
    check_eq("tri.id",    ev_if.out_orderID, 64'h300);

    // Saturation of the 3-bit drop counter: 4 -> 6 -> 7 -> 7
    ev_if.out_ready = 1'b1;
    add_valid = 1; exec_valid = 1; del_valid = 1;
    tick();
    check_eq("sat.1", 64'(drop_cnt), 64'd6);
    tick();
    check_eq("sat.2", 64'(drop_cnt), 64'd7);
    tick();
    check_eq("sat.3", 64'(drop_cnt), 64'd7);
    check_eq("sat.level", 64'(level), 64'd1);
    add_valid = 0; exec_valid = 0; del_valid = 0;
    tick();
    check_eq("sat.empty", 64'(level), 64'd0);

    // Reset mid-stream with a strobe present
    ev_if.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_add(64'h400 + 64'(i), 64'd3, 32'd4, 8'h42);
      tick();
    end
    add_valid = 0;
    check_eq("mid.level", 64'(level), 64'd5);
    rst = 1'b0; del_valid = 1;
    tick();
    rst = 1'b1; del_valid = 0;
    check_eq("mid.rst.level", 64'(level), 64'd0);
    check_eq("mid.rst.valid", 64'(ev_if.out_valid), 64'd0);
    check_eq("mid.rst.drop",  64'(drop_cnt), 64'd0);
    check_eq("mid.rst.id",    ev_if.out_orderID, 64'd0);
    drive_add(64'hABC, 64'd9, 32'd10, 8'h53);
    tick();
    add_valid = 0;
    check_head("post", 2'd0, 64'hABC, 64'd9, 32'd10);
    check_eq("post.level", 64'(level), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/itch_order_event_fifo.md
# itch_order_event_fifo

Downstream stage of the ITCH message parser top. Collects the one-cycle completion strobes and field outputs of the add-order (no MPID), order-executed and order-delete parsers. Each completed message becomes a normalised order event in a show-ahead FIFO. The order-book update logic drains the FIFO through a valid/ready handshake.

## Interface
- DEPTH, 8: FIFO entries; power of two, 2..64.
- CNT_W, 16: width of the drop counter.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- add_valid  input  1  one-cycle pulse; add-order fields valid this cycle.
- exec_valid  input  1  one-cycle pulse; order-executed fields valid this cycle.
- del_valid  input  1  one-cycle pulse; order-delete fields valid this cycle.
- add_timeStamp / exec_timeStamp / del_timeStamp  input  32 each  message timestamp.
- add_orderID / exec_orderID / del_orderID  input  64 each  order ID.
- add_orderBookID / exec_orderBookID / del_orderBookID  input  32 each  order book ID.
- add_side / exec_side / del_side  input  8 each  side byte, ASCII 'B' or 'S'.
- add_quantity / exec_executedQuantity  input  64 each  quantity.
- add_price  input  32  limit price.
- out_ready  input  1  consumer accepts the head entry.
- out_valid  output  1  head entry present.
- out_type  output  2  event type: 0 = ADD, 1 = EXEC, 2 = DELETE; 3 is never produced.
- out_timeStamp  output  32  head timestamp.
- out_orderID  output  64  head order ID.
- out_orderBookID  output  32  head order book ID.
- out_side  output  8  head side.
- out_quantity  output  64  head quantity.
- out_price  output  32  head price.
- level  output  $clog2(DEPTH)+1  current occupancy.
- drop_cnt  output  CNT_W  saturating count of lost events.

## Operation
- Event normalisation:
  - ADD carries all add fields.
  - EXEC carries exec fields, with out_price = 0.
  - DELETE carries del fields, with out_quantity = 0 and out_price = 0.
- Simultaneous strobes: fixed priority ADD > EXEC > DELETE. Only the winner is a push candidate. Each losing strobe increments drop_cnt by 1, so up to +2 in one cycle.
- Push rule: push when a candidate exists and either (level < DEPTH) or (pop in the same cycle).
  - If a candidate exists while full and no pop occurs, the event is dropped and drop_cnt increments by 1.
  - Priority losses and an overflow drop in the same cycle add together.
- Pop rule: pop when out_valid && out_ready. Pop on empty is impossible because out_valid = 0.
- Simultaneous push and pop: level is unchanged and both pointers advance.
- drop_cnt saturates at 2^CNT_W − 1 and never wraps.
- Storage: dual-pointer circular buffer with wrap-bit pointers. Full and empty are derived from the pointers; level = wr_ptr − rd_ptr in modulo 2·DEPTH arithmetic.
- Out fields are driven combinationally from the entry at rd_ptr (show-ahead).
- Out fields must stay stable while out_valid && !out_ready.
- Field values are don't-care while out_valid = 0.
- Reset (rst = 0 at a clock edge):
  - Pointers, level and drop_cnt are cleared to 0; out_valid = 0.
  - Entries already stored are discarded, including when reset arrives mid-stream.
  - Strobes in reset cycles are ignored and not counted.

## Timing
- Reset values: out_valid 0, level 0, drop_cnt 0, all out_* fields 0.
- Storage contents are zeroed on reset.
- Push latency: a strobe sampled at edge N makes out_valid = 1 and the event visible at the head after edge N (in cycle N+1) if the FIFO was empty. No bypass in the same cycle.
- Pop: at the edge where out_valid && out_ready, the head advances. The next entry is presented in the following cycle, or out_valid falls if that was the last entry.
- Throughput: one push and one pop per cycle sustained; the full FIFO never stalls upstream because it has no backpressure path.
- The upstream parsers have no ready signal, so loss is reported only through drop_cnt.
- level and drop_cnt are registered and update at the same edge as the push, pop or drop.

## Test plan
- Single add: add_valid pulse with orderID 0x1122334455667788, quantity 100, price 2500, side 'B', out_ready = 1 → in the next cycle out_valid = 1, out_type = 0 with matching fields. After one pop, level = 0 and out_valid = 0.
- Mixed stream with out_ready held 0: ADD, then EXEC with executedQuantity 40, then DELETE → level = 3. Releasing out_ready drains in order with types 0, 1, 2; the EXEC entry has price 0 and the DELETE entry has quantity 0 and price 0.
- Overflow at DEPTH = 8: 10 add pulses with out_ready = 0 → level = 8, drop_cnt = 2. The draining order is the first 8 orderIDs.
- Full plus simultaneous events: with the FIFO full, pulse add_valid in the cycle where out_ready = 1 → push accepted, level stays 8, drop_cnt unchanged.
- Simultaneous strobes: add_valid, exec_valid and del_valid together into an empty FIFO → only the ADD is stored, level = 1, drop_cnt = 2.
- Reset mid-operation: with 5 entries queued, hold rst = 0 for one cycle while del_valid = 1 → level = 0, out_valid = 0, drop_cnt = 0. A later single push then appears normally.
